// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - n-gram temporal encoder binding consecutive spatial hypervectors
`ifndef HV_DIMENSION
`define HV_DIMENSION 1024
`endif

module temporal_encoder #(
  parameter int HV_DIMENSION = `HV_DIMENSION,
  parameter int NGRAM_SIZE   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  output logic                    hvout_valid,
  input  logic                    hvout_ready,
  output logic [HV_DIMENSION-1:0] hvout
);

  localparam int                FILL_W   = $clog2(NGRAM_SIZE);
  localparam int                HIST_N   = NGRAM_SIZE - 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NGRAM_SIZE - 1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  typedef enum logic {
    WARMUP = 1'b0,
    STEADY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [HV_DIMENSION-1:0] hist_q [HIST_N];
  logic [HV_DIMENSION-1:0] hist_d [HIST_N];
  logic [HV_DIMENSION-1:0] hvout_q, hvout_d;
  logic                    valid_q, valid_d;
  logic [HV_DIMENSION-1:0] ngram;
  logic                    din_fire;
  logic                    hvout_fire;

  // Left circular rotate: out[i] = x[(i-k) mod HV_DIMENSION]
  function automatic logic [HV_DIMENSION-1:0] rho(input logic [HV_DIMENSION-1:0] x, input int k);
    rho = (x << k) | (x >> (HV_DIMENSION - k));
  endfunction

  assign din_ready   = !valid_q || hvout_ready;
  assign din_fire    = din_valid && din_ready;
  assign hvout_fire  = valid_q && hvout_ready;
  assign hvout_valid = valid_q;
  assign hvout       = hvout_q;

  // Bind the incoming HV with the rotated history; older terms get larger rotations
  always_comb begin
    ngram = hvin;
    for (int k = 1; k < NGRAM_SIZE; k++) begin
      ngram = ngram ^ rho(hist_q[k-1], k);
    end
  end

  // Next-state: history shift, fill/state tracking and output register update
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    hvout_d = hvout_q;
    valid_d = valid_q;

    if (hvout_fire) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      // Flush restarts warm-up; an HV accepted in the same cycle becomes the oldest term
      for (int k = 0; k < HIST_N; k++) begin
        hist_d[k] = '0;
      end
      fill_d  = '0;
      state_d = WARMUP;
      if (din_fire) begin
        hist_d[0] = hvin;
        fill_d    = FILL_ONE;
        state_d   = (FILL_ONE == FILL_MAX) ? STEADY : WARMUP;
      end
    end else if (din_fire) begin
      for (int k = HIST_N - 1; k > 0; k--) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0] = hvin;
      if (state_q == STEADY) begin
        hvout_d = ngram;
        valid_d = 1'b1;
      end else begin
        fill_d  = fill_q + 1'b1;
        state_d = (fill_d == FILL_MAX) ? STEADY : WARMUP;
      end
    end
  end

  // State register with asynchronous flush of everything on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WARMUP;
      fill_q  <= '0;
      for (int k = 0; k < HIST_N; k++) begin
        hist_q[k] <= '0;
      end
      hvout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      hvout_q <= hvout_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb/tb_temporal_encoder.sv - directed self-checking bench for temporal_encoder
module tb_temporal_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] hvin;
  logic       hvout_valid;
  logic       hvout_ready;
  logic [7:0] hvout;

  int n_cmp = 0;
  int n_bad = 0;

  temporal_encoder #(
    .HV_DIMENSION(8),
    .NGRAM_SIZE  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .hvin       (hvin),
    .hvout_valid(hvout_valid),
    .hvout_ready(hvout_ready),
    .hvout      (hvout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one HV for exactly one edge, sample 1 time unit after it
  task automatic push(input logic [7:0] v);
    din_valid = 1'b1;
    hvin      = v;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    clear       = 1'b0;
    din_valid   = 1'b0;
    hvin        = 8'h00;
    hvout_ready = 1'b1;
    #12;
    check("reset_valid", 32'(hvout_valid), 32'h0);
    check("reset_hvout", 32'(hvout), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    idle();
    check("post_reset_ready", 32'(din_ready), 32'h1);

    // Warm-up then steady state with rotation wrap
    push(8'h01);
    check("warm1_valid", 32'(hvout_valid), 32'h0);
    push(8'h02);
    check("warm2_valid", 32'(hvout_valid), 32'h0);
    push(8'h04);
    check("first_valid", 32'(hvout_valid), 32'h1);
    check("first_hvout", 32'(hvout), 32'h04);
    push(8'h80);
    check("steady1_valid", 32'(hvout_valid), 32'h1);
    check("steady1_hvout", 32'(hvout), 32'h80);
    push(8'h40);
    check("steady2_hvout", 32'(hvout), 32'h51);

    // Backpressure: pending output blocks input, then drain and accept together
    hvout_ready = 1'b0;
    din_valid   = 1'b1;
    hvin        = 8'h20;
    #1;
    check("bp_ready_low", 32'(din_ready), 32'h0);
    @(posedge clk);
    #1;
    check("bp_hold_valid", 32'(hvout_valid), 32'h1);
    check("bp_hold_hvout", 32'(hvout), 32'h51);
    hvout_ready = 1'b1;
    #1;
    check("bp_ready_high", 32'(din_ready), 32'h1);
    push(8'h20);
    check("bp_next_valid", 32'(hvout_valid), 32'h1);
    check("bp_next_hvout", 32'(hvout), 32'hA2);
    idle();
    check("drain_valid", 32'(hvout_valid), 32'h0);

    // Clear flushes history but leaves the output register alone
    clear = 1'b1;
    idle();
    clear = 1'b0;
    check("clear_keeps_hvout", 32'(hvout), 32'hA2);
    push(8'h01);
    check("clr_warm1_valid", 32'(hvout_valid), 32'h0);
    push(8'h02);
    check("clr_warm2_valid", 32'(hvout_valid), 32'h0);
    push(8'h04);
    check("clr_out_valid", 32'(hvout_valid), 32'h1);
    check("clr_out_hvout", 32'(hvout), 32'h04);

    // Clear together with an accept: that HV becomes the oldest term
    clear = 1'b1;
    push(8'h10);
    clear = 1'b0;
    check("clrfire_valid", 32'(hvout_valid), 32'h0);
    push(8'h03);
    check("clrfire_warm_valid", 32'(hvout_valid), 32'h0);
    push(8'h05);
    check("clrfire_out_valid", 32'(hvout_valid), 32'h1);
    check("clrfire_out_hvout", 32'(hvout), 32'h43);

    // Reset mid-operation with an undrained output
    hvout_ready = 1'b0;
    idle();
    check("pre_rst_valid", 32'(hvout_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(hvout_valid), 32'h0);
    check("async_rst_hvout", 32'(hvout), 32'h00);
    @(negedge clk);
    rst         = 1'b1;
    hvout_ready = 1'b1;
    idle();
    check("rst2_ready", 32'(din_ready), 32'h1);
    push(8'h0F);
    check("rst_warm1_valid", 32'(hvout_valid), 32'h0);
    push(8'h01);
    check("rst_warm2_valid", 32'(hvout_valid), 32'h0);
    push(8'h00);
    check("rst_out_valid", 32'(hvout_valid), 32'h1);
    check("rst_out_hvout", 32'(hvout), 32'h3E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
